// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR filter built around a single signed MAC.
// One sample is accepted, NTAPS MAC cycles run over a circular delay line,
// one post-processing cycle applies round/shift/saturate, and the result is
// held in OUT until the consumer accepts it.
module fir_mac_seq #(
   parameter int NTAPS       = 4,
   parameter int DATA_W      = 18,
   parameter int COEF_W      = 20,
   parameter int OUT_W       = 20,
   parameter int SHIFT_RIGHT = 10,
   parameter int ROUND       = 1,
   parameter int SATURATE    = 1
) (
   input  logic                       clock_i,
   input  logic                       reset_n_i,
   input  logic                       clear_i,
   input  logic                       coef_we_i,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr_i,
   input  logic [COEF_W-1:0]          coef_data_i,
   output logic                       coef_ready_o,
   input  logic                       in_valid_i,
   input  logic [DATA_W-1:0]          in_data_i,
   output logic                       in_ready_o,
   output logic                       out_valid_o,
   output logic [OUT_W-1:0]           out_data_o,
   output logic                       out_sat_o,
   input  logic                       out_ready_i,
   output logic                       busy_o
);

   localparam int AW    = $clog2(NTAPS);
   localparam int PW    = DATA_W + COEF_W;
   localparam int ACC_W = PW + AW;
   // one extra bit so the rounding constant can never wrap the sum
   localparam int RW    = ACC_W + 1;
   // compare width: wide enough to hold both the shifted sum and the OUT_W limits
   localparam int EW    = (RW > OUT_W) ? RW : OUT_W + 1;
   localparam int RSH   = (SHIFT_RIGHT > 0) ? SHIFT_RIGHT - 1 : 0;
   localparam logic signed [RW-1:0] RND =
      (ROUND != 0 && SHIFT_RIGHT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RSH) : '0;
   localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_POST, S_OUT} state_t;

   state_t                    state_q, state_d;
   logic [AW-1:0]             head_q, head_d;
   logic [AW-1:0]             rd_q, rd_d;
   logic [AW-1:0]             k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [DATA_W-1:0]  dl_q [NTAPS];
   logic signed [DATA_W-1:0]  dl_d [NTAPS];
   logic signed [COEF_W-1:0]  coef_q [NTAPS];
   logic signed [COEF_W-1:0]  coef_d [NTAPS];
   logic                      ov_q, ov_d;
   logic [OUT_W-1:0]          od_q, od_d;
   logic                      os_q, os_d;

   logic signed [PW-1:0]      prod;
   logic signed [RW-1:0]      sum_r;
   logic signed [RW-1:0]      shr;
   logic signed [EW-1:0]      ext;
   logic [OUT_W-1:0]          post_data;
   logic                      post_sat;
   logic [AW-1:0]             head_nxt;

   assign prod     = PW'(dl_q[rd_q]) * PW'(coef_q[k_q]);
   assign head_nxt = (head_q == LAST) ? '0 : head_q + AW'(1);

   // round, arithmetic shift and optional clamp of the finished accumulator
   always_comb begin
      sum_r     = RW'(acc_q) + RND;
      shr       = sum_r >>> SHIFT_RIGHT;
      ext       = EW'(shr);
      post_data = ext[OUT_W-1:0];
      post_sat  = 1'b0;
      if (SATURATE != 0) begin
         if (ext > MAX_V) begin
            post_data = MAX_V[OUT_W-1:0];
            post_sat  = 1'b1;
         end else if (ext < MIN_V) begin
            post_data = MIN_V[OUT_W-1:0];
            post_sat  = 1'b1;
         end
      end
   end

   // sample accept is clear-gated in IDLE and pass-through of the consumer in OUT
   always_comb begin
      in_ready_o = 1'b0;
      case (state_q)
         S_IDLE:  in_ready_o = !clear_i;
         S_OUT:   in_ready_o = out_ready_i;
         default: in_ready_o = 1'b0;
      endcase
   end

   assign coef_ready_o = (state_q == S_IDLE);
   assign busy_o       = (state_q != S_IDLE);
   assign out_valid_o  = ov_q;
   assign out_data_o   = od_q;
   assign out_sat_o    = os_q;

   // next-state and datapath updates for the IDLE/MAC/POST/OUT sequence
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      rd_d    = rd_q;
      k_d     = k_q;
      acc_d   = acc_q;
      dl_d    = dl_q;
      coef_d  = coef_q;
      ov_d    = ov_q;
      od_d    = od_q;
      os_d    = os_q;
      case (state_q)
         S_IDLE: begin
            if (coef_we_i && (int'(coef_addr_i) < NTAPS))
               coef_d[coef_addr_i] = coef_data_i;
            if (clear_i) begin
               for (int i = 0; i < NTAPS; i++) dl_d[i] = '0;
            end else if (in_valid_i) begin
               dl_d[head_q] = in_data_i;
               rd_d         = head_q;
               acc_d        = '0;
               k_d          = '0;
               state_d      = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            rd_d  = (rd_q == '0) ? LAST : rd_q - AW'(1);
            k_d   = k_q + AW'(1);
            if (k_q == LAST) state_d = S_POST;
         end
         S_POST: begin
            ov_d    = 1'b1;
            od_d    = post_data;
            os_d    = post_sat;
            state_d = S_OUT;
         end
         default: begin
            if (out_ready_i) begin
               ov_d   = 1'b0;
               head_d = head_nxt;
               if (in_valid_i) begin
                  // back-to-back: next sample lands at the advanced head
                  dl_d[head_nxt] = in_data_i;
                  rd_d           = head_nxt;
                  acc_d          = '0;
                  k_d            = '0;
                  state_d        = S_MAC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // state register; reset discards any in-flight computation
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         head_q  <= '0;
         rd_q    <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         os_q    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            dl_q[i]   <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         rd_q    <= rd_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         os_q    <= os_d;
         dl_q    <= dl_d;
         coef_q  <= coef_d;
      end
   end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: five parameterisations share one stimulus bus,
// gated by sel, so a single set of tasks exercises all of them.
module tb_fir_mac_seq;

   logic        clk, rst_n, clr, coef_we, in_valid, out_ready;
   logic [1:0]  coef_addr;
   logic [19:0] coef_data;
   logic [17:0] in_data;
   logic [2:0]  sel;
   logic [4:0]  ov, os, ir, cr, bz;
   logic [19:0] od0, od1, od2;
   logic [15:0] od3, od4;
   logic        ov_s, os_s, ir_s, cr_s, bz_s;
   logic [19:0] od_s;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic [2:0]  sel;
      logic        clr;
      logic [17:0] x;
      logic [19:0] y;
      logic        s;
   } vec_t;
   vec_t vecs[14];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 0: defaults
   fir_mac_seq u0 (.clock_i(clk), .reset_n_i(rst_n), .clear_i(clr && sel == 3'd0),
      .coef_we_i(coef_we && sel == 3'd0), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
      .coef_ready_o(cr[0]), .in_valid_i(in_valid && sel == 3'd0), .in_data_i(in_data),
      .in_ready_o(ir[0]), .out_valid_o(ov[0]), .out_data_o(od0), .out_sat_o(os[0]),
      .out_ready_i(out_ready), .busy_o(bz[0]));
   // 1: two taps, rounding
   fir_mac_seq #(.NTAPS(2), .ROUND(1)) u1 (.clock_i(clk), .reset_n_i(rst_n),
      .clear_i(clr && sel == 3'd1), .coef_we_i(coef_we && sel == 3'd1),
      .coef_addr_i(coef_addr[0:0]), .coef_data_i(coef_data), .coef_ready_o(cr[1]),
      .in_valid_i(in_valid && sel == 3'd1), .in_data_i(in_data), .in_ready_o(ir[1]),
      .out_valid_o(ov[1]), .out_data_o(od1), .out_sat_o(os[1]), .out_ready_i(out_ready),
      .busy_o(bz[1]));
   // 2: two taps, no rounding
   fir_mac_seq #(.NTAPS(2), .ROUND(0)) u2 (.clock_i(clk), .reset_n_i(rst_n),
      .clear_i(clr && sel == 3'd2), .coef_we_i(coef_we && sel == 3'd2),
      .coef_addr_i(coef_addr[0:0]), .coef_data_i(coef_data), .coef_ready_o(cr[2]),
      .in_valid_i(in_valid && sel == 3'd2), .in_data_i(in_data), .in_ready_o(ir[2]),
      .out_valid_o(ov[2]), .out_data_o(od2), .out_sat_o(os[2]), .out_ready_i(out_ready),
      .busy_o(bz[2]));
   // 3: 16-bit output, saturating
   fir_mac_seq #(.OUT_W(16), .SATURATE(1)) u3 (.clock_i(clk), .reset_n_i(rst_n),
      .clear_i(clr && sel == 3'd3), .coef_we_i(coef_we && sel == 3'd3),
      .coef_addr_i(coef_addr), .coef_data_i(coef_data), .coef_ready_o(cr[3]),
      .in_valid_i(in_valid && sel == 3'd3), .in_data_i(in_data), .in_ready_o(ir[3]),
      .out_valid_o(ov[3]), .out_data_o(od3), .out_sat_o(os[3]), .out_ready_i(out_ready),
      .busy_o(bz[3]));
   // 4: 16-bit output, wrapping
   fir_mac_seq #(.OUT_W(16), .SATURATE(0)) u4 (.clock_i(clk), .reset_n_i(rst_n),
      .clear_i(clr && sel == 3'd4), .coef_we_i(coef_we && sel == 3'd4),
      .coef_addr_i(coef_addr), .coef_data_i(coef_data), .coef_ready_o(cr[4]),
      .in_valid_i(in_valid && sel == 3'd4), .in_data_i(in_data), .in_ready_o(ir[4]),
      .out_valid_o(ov[4]), .out_data_o(od4), .out_sat_o(os[4]), .out_ready_i(out_ready),
      .busy_o(bz[4]));

   // observe the selected instance
   always_comb begin
      ov_s = ov[sel];
      os_s = os[sel];
      ir_s = ir[sel];
      cr_s = cr[sel];
      bz_s = bz[sel];
      case (sel)
         3'd0:    od_s = od0;
         3'd1:    od_s = od1;
         3'd2:    od_s = od2;
         3'd3:    od_s = {4'h0, od3};
         default: od_s = {4'h0, od4};
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int ntaps_of(input logic [2:0] s);
      return (s == 3'd1 || s == 3'd2) ? 2 : 4;
   endfunction

   task automatic wr_coef(input logic [1:0] a, input logic [19:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!ov_s && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic send(input logic [17:0] x, output logic [19:0] y, output logic s,
                       output int lat);
      in_valid = 1'b1; in_data = x;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      y = od_s; s = os_s;
      handshake();
   endtask

   initial begin
      logic [19:0] y, y_hold;
      logic        s;
      int          lat;
      bit          seen;

      vecs[0]  = '{3'd0, 1'b0, 18'h00400, 20'h0000B, 1'b0};
      vecs[1]  = '{3'd0, 1'b0, 18'h00000, 20'h0000E, 1'b0};
      vecs[2]  = '{3'd0, 1'b0, 18'h00000, 20'h0000E, 1'b0};
      vecs[3]  = '{3'd0, 1'b0, 18'h00000, 20'h0000F, 1'b0};
      vecs[4]  = '{3'd0, 1'b0, 18'h00000, 20'h00000, 1'b0};
      vecs[5]  = '{3'd0, 1'b0, 18'h00800, 20'h00016, 1'b0};
      vecs[6]  = '{3'd1, 1'b0, 18'h00200, 20'h00002, 1'b0};
      vecs[7]  = '{3'd1, 1'b0, 18'h3FE00, 20'hFFFFF, 1'b0};
      vecs[8]  = '{3'd2, 1'b0, 18'h00200, 20'h00001, 1'b0};
      vecs[9]  = '{3'd2, 1'b0, 18'h3FE00, 20'hFFFFE, 1'b0};
      vecs[10] = '{3'd3, 1'b0, 18'h1FFFF, 20'h07FFF, 1'b1};
      vecs[11] = '{3'd3, 1'b1, 18'h20001, 20'h08000, 1'b1};
      vecs[12] = '{3'd4, 1'b0, 18'h1FFFF, 20'h0FD80, 1'b0};
      vecs[13] = '{3'd4, 1'b1, 18'h20001, 20'h00280, 1'b0};

      rst_n = 1'b0; clr = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      coef_addr = '0; coef_data = '0; in_data = '0; sel = 3'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(ov_s), 32'd0);
      chk("rst_out_data", 32'(od_s), 32'd0);
      chk("rst_out_sat", 32'(os_s), 32'd0);
      chk("rst_busy", 32'(bz_s), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 32'(ir_s), 32'd1);
      chk("idle_coef_ready", 32'(cr_s), 32'd1);

      // coefficient banks
      sel = 3'd0;
      wr_coef(2'd0, 20'h0000B); wr_coef(2'd1, 20'h0000E);
      wr_coef(2'd2, 20'h0000E); wr_coef(2'd3, 20'h0000F);
      sel = 3'd1; wr_coef(2'd0, 20'h00003);
      sel = 3'd2; wr_coef(2'd0, 20'h00003);
      for (int k = 3; k <= 4; k++) begin
         sel = 3'(k);
         for (int a = 0; a < 4; a++) wr_coef(2'(a), 20'h7FFFF);
      end

      // table: impulse response, rounding, saturation/wrap
      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         if (vecs[i].clr) do_clear();
         send(vecs[i].x, y, s, lat);
         chk($sformatf("v%0d_data", i), 32'(y), 32'(vecs[i].y));
         chk($sformatf("v%0d_sat", i), 32'(s), 32'(vecs[i].s));
         chk($sformatf("v%0d_latency", i), lat, ntaps_of(vecs[i].sel) + 1);
      end

      // backpressure with back-to-back accept
      sel = 3'd0;
      do_clear();
      in_valid = 1'b1; in_data = 18'h00400;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      chk("bp_first_latency", lat, 5);
      y_hold = od_s;
      chk("bp_first_data", 32'(y_hold), 32'h0000B);
      in_valid = 1'b1; in_data = 18'h00800;
      for (int c = 0; c < 7; c++) begin
         #1;
         chk("bp_valid_held", 32'(ov_s), 32'd1);
         chk("bp_data_held", 32'(od_s), 32'(y_hold));
         chk("bp_sat_held", 32'(os_s), 32'd0);
         chk("bp_in_ready_low", 32'(ir_s), 32'd0);
         chk("bp_busy", 32'(bz_s), 32'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_in_ready_follows", 32'(ir_s), 32'd1);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      chk("bp_direct_mac_busy", 32'(bz_s), 32'd1);
      chk("bp_direct_mac_valid", 32'(ov_s), 32'd0);
      wait_out(lat);
      chk("bp_second_latency", lat, 5);
      chk("bp_second_data", 32'(od_s), 32'h00024);
      handshake();

      // clear together with a sample: clear wins
      clr = 1'b1; in_valid = 1'b1; in_data = 18'h00100;
      #1 chk("clr_in_ready", 32'(ir_s), 32'd0);
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_no_accept", 32'(bz_s), 32'd0);

      // coefficient write during MAC is ignored; clean impulse after clear
      in_valid = 1'b1; in_data = 18'h00400;
      @(negedge clk);
      in_valid = 1'b0;
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 20'h00100;
      #1 chk("mac_coef_ready", 32'(cr_s), 32'd0);
      wait_out(lat);
      chk("mac_wr_data", 32'(od_s), 32'h0000B);
      coef_we = 1'b0;
      handshake();

      // write in IDLE together with accept: new c0 applies to this sample
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 20'h00015;
      in_valid = 1'b1; in_data = 18'h00400;
      @(negedge clk);
      coef_we = 1'b0; in_valid = 1'b0;
      wait_out(lat);
      chk("idle_wr_data", 32'(od_s), 32'h00023);
      handshake();

      // asynchronous reset mid-MAC
      in_valid = 1'b1; in_data = 18'h00400;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(bz_s), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(bz_s), 32'd0);
      chk("async_rst_valid", 32'(ov_s), 32'd0);
      chk("async_rst_data", 32'(od_s), 32'd0);
      chk("async_rst_in_ready", 32'(ir_s), 32'd1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (ov_s) seen = 1'b1;
         @(negedge clk);
      end
      chk("rst_discard", 32'(seen), 32'd0);
      send(18'h00400, y, s, lat);
      chk("post_rst_data", 32'(y), 32'd0);
      chk("post_rst_latency", lat, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
